lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store sequencer between the pipeline MEM stage and a variable-latency data memory.
//  Accepts one load or store per handshake and checks alignment.
//  Drives a word-aligned memory request with byte enables, then waits for the ack with a timeout.
//  Returns the raw read word, funct3 and byte offset to the load-extension logic, and stalls the pipeline meanwhile.
// PARAMETERS
//  DATA_WIDTH     32  data word width (byte lanes = DATA_WIDTH/8 = 4)
//  ADDRESS_WIDTH  32  byte address width
//  TIMEOUT        16  max cycles mem_req is held without mem_ack before error (>=2)
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     synchronous reset, active-high
//  req_valid   in   1     MEM stage has a load/store
//  req_ready   out  1     controller can accept a request
//  req_we      in   1     1 = store, 0 = load
//  req_funct3  in   3     RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//  req_addr    in   AW    byte address
//  req_wdata   in   DW    store data (rs2), LSB-justified
//  mem_req     out  1     memory request, held until mem_ack
//  mem_we      out  1     memory write enable
//  mem_addr    out  AW    req_addr with bits [1:0] forced to 0
//  mem_wdata   out  DW    lane-replicated store data
//  mem_be      out  4     byte-lane enables
//  mem_ack     in   1     memory done; mem_rdata valid this cycle for loads
//  mem_rdata   in   DW    memory read word
//  rsp_valid   out  1     one-cycle completion pulse
//  rsp_rword   out  DW    captured read word (0 for stores/errors)
//  rsp_funct3  out  3     latched funct3
//  rsp_offset  out  2     latched req_addr[1:0]
//  rsp_err     out  1     misaligned, illegal funct3, or timeout (valid with rsp_valid)
//  stall       out  1     hold the pipeline
// BEHAVIOUR
//  Reset: state=IDLE, timeout counter=0, all latches=0.
//   mem_req, mem_we, rsp_valid, rsp_err and stall are 0; mem_be=0; rsp_rword=0.
//   req_ready=0 while rst is high and 1 in IDLE after reset.
//  FSM states: IDLE, ACCESS, RESP.
//  IDLE: req_ready=1. Accept on req_valid&req_ready and latch we, funct3, addr, wdata.
//   Illegal: stores with funct3 other than 000/001/010; loads with funct3 011/11x.
//   Misaligned: h/hu/sh with addr[0]=1; w with addr[1:0]!=0.
//   Illegal or misaligned -> RESP with err=1, no memory access. Otherwise -> ACCESS with counter=0.
//  ACCESS: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata are stable from latches.
//   Load: mem_be=1111, mem_we=0.
//   sb: be = 0001<<off, wdata = {4{wdata[7:0]}}.
//   sh: be = off[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
//   sw: be = 1111, wdata unchanged.
//   mem_ack=1 -> capture mem_rdata (loads) and go to RESP with err=0.
//   No ack: counter += 1. When counter==TIMEOUT-1 and no ack -> RESP with err=1.
//   mem_ack in the first ACCESS cycle is legal.
//  RESP: rsp_valid=1 for exactly one cycle; rsp_* hold latched values; -> IDLE. req_ready=0.
//  Outputs are decoded from registered state; mem_req drops in the cycle after ack.
//  stall = (IDLE & req_valid) | ACCESS; it is 0 in RESP so the pipeline advances on rsp_valid.
//  Latency: accept at cycle T, ack at T+1 -> rsp_valid at T+2 (minimum).
//   Error without access -> rsp_valid at T+1.
//  mem_ack while not in ACCESS is ignored.
//  rst asserted mid-ACCESS -> IDLE next cycle; mem_req=0; the pending op is dropped with no rsp_valid.
//  rsp_rword/offset/funct3 hold their values after RESP until the next capture.
// TESTING
//  lw 0x100, ack on 1st ACCESS cycle, rdata 0xDEADBEEF -> mem_be=1111, rsp_valid at T+2, rword=DEADBEEF, err=0.
//  sb addr 0x103 wdata 0x000000A5 -> mem_addr=0x100, be=1000, wdata=A5A5A5A5, mem_we=1.
//  sh at 0x102 wdata 0x1234 -> be=1100, wdata=12341234; lh at 0x101 -> rsp_err=1, no mem_req, rsp at T+1.
//  No ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, then rsp_valid with rsp_err=1, stall falls.
//  Ack delayed 5 cycles with req_valid held -> stall=1 throughout, req_ready=0, single rsp_valid pulse.
//  rst in 3rd ACCESS cycle, then stray ack -> mem_req=0 next cycle, no rsp_valid, back to IDLE with req_ready=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a variable-latency data memory:
// alignment/funct3 check, word-aligned request with byte enables, ack timeout.
//
// state  | meaning
// IDLE   | waiting for a MEM-stage request, req_ready high
// ACCESS | mem_req held from latched request, waiting for mem_ack or timeout
// RESP   | one-cycle rsp_valid with latched results, pipeline released

module lsu_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic                     mem_ack,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rword,
  output logic [2:0]               rsp_funct3,
  output logic [1:0]               rsp_offset,
  output logic                     rsp_err,
  output logic                     stall
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rword_q;
  logic                     err_q;
  logic                     bad_op;
  logic                     misal;

  // Stores only allow b/h/w; loads reject 011, 110, 111.
  always_comb begin
    if (req_we) bad_op = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else        bad_op = (req_funct3[1:0] == 2'b11) | (req_funct3[2:1] == 2'b11);
    misal = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
            ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (bad_op | misal) begin
              rword_q <= '0;
              err_q   <= 1'b1;
              state   <= RESP;
            end else begin
              cnt   <= '0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            rword_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
            state   <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rword_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lane replication lets the memory pick bytes by mem_be alone.
  always_comb begin
    mem_wdata = wdata_q;
    mem_be    = 4'b0000;
    case (f3_q[1:0])
      2'b00:   mem_wdata = {(DATA_WIDTH/8){wdata_q[7:0]}};
      2'b01:   mem_wdata = {(DATA_WIDTH/16){wdata_q[15:0]}};
      default: mem_wdata = wdata_q;
    endcase
    if (state == ACCESS) begin
      if (!we_q) begin
        mem_be = 4'b1111;
      end else begin
        case (f3_q[1:0])
          2'b00:   mem_be = 4'b0001 << addr_q[1:0];
          2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
          default: mem_be = 4'b1111;
        endcase
      end
    end
  end

  assign req_ready  = ~rst & (state == IDLE);
  assign mem_req    = (state == ACCESS);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign rsp_valid  = (state == RESP);
  assign rsp_err    = rsp_valid & err_q;
  assign rsp_rword  = rword_q;
  assign rsp_funct3 = f3_q;
  assign rsp_offset = addr_q[1:0];
  assign stall      = ~rst & (((state == IDLE) & req_valid) | (state == ACCESS));

endmodule
